ballot_collector: RTL and testbench

BALLOT_COLLECTOR -- requirements
Module: ballot_collector

---
 rtl/vote_pkg.sv | 11 +
 rtl/vote_window_timer.sv | 29 ++
 rtl/ballot_collector.sv | 110 +++++++++++
 tb/tb_ballot_collector.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared types and constants for the ballot collector slice.
package vote_pkg;
  localparam int unsigned NUM_VOTERS = 4;
  localparam int unsigned WIN_W      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    HOLD = 2'd2
  } state_t;
endpackage

// File: rtl/vote_window_timer.sv
// Voting-window countdown: loads a cycle count, decrements while enabled,
// and flags the enabled cycle on which the count reaches zero.
module vote_window_timer
  import vote_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIN_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [WIN_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  // A zero count while enabled also expires so the window can never stick open.
  assign expired = en && (r_count <= WIN_W'(1));

endmodule

// File: rtl/ballot_collector.sv
// Collects per-voter strobed votes over a bounded window and presents the
// ballot with a valid/ready handshake. Define BALLOT_LOCK_EN to make the
// first vote from each voter final (default: last vote wins).
module ballot_collector #(
  parameter int unsigned NUM_VOTERS    = 4,
  parameter int unsigned WINDOW_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_VOTERS-1:0] vote_stb,
  input  logic [NUM_VOTERS-1:0] vote_val,
  output logic                  busy,
  output logic [NUM_VOTERS-1:0] ballot,
  output logic [NUM_VOTERS-1:0] voted,
  output logic                  ballot_valid,
  input  logic                  ballot_ready
);
  import vote_pkg::*;

  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW_CYCLES);

  state_t                r_state;
  logic [NUM_VOTERS-1:0] r_ballot;
  logic [NUM_VOTERS-1:0] r_voted;
  logic                  r_busy;
  logic                  r_valid;

  logic                  w_load;
  logic                  w_en;
  logic                  w_expired;
  logic [NUM_VOTERS-1:0] w_ballot_nxt;
  logic [NUM_VOTERS-1:0] w_voted_nxt;

  assign w_load = (r_state == IDLE) && start;
  assign w_en   = (r_state == OPEN);

  vote_window_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (WIN_LOAD),
    .en       (w_en),
    .expired  (w_expired)
  );

  always_comb begin
    w_ballot_nxt = r_ballot;
    w_voted_nxt  = r_voted | vote_stb;
    for (int unsigned n = 0; n < NUM_VOTERS; n++) begin
`ifdef BALLOT_LOCK_EN
      if (vote_stb[n] && !r_voted[n]) begin
        w_ballot_nxt[n] = vote_val[n];
      end
`else
      if (vote_stb[n]) begin
        w_ballot_nxt[n] = vote_val[n];
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ballot <= '0;
      r_voted  <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state  <= OPEN;
            r_ballot <= '0;
            r_voted  <= '0;
            r_busy   <= 1'b1;
          end
        end
        OPEN: begin
          r_ballot <= w_ballot_nxt;
          r_voted  <= w_voted_nxt;
          // Close on the same edge that captures the last strobe or the final window cycle.
          if ((&w_voted_nxt) || w_expired) begin
            r_state <= HOLD;
            r_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (ballot_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign ballot       = r_ballot;
  assign voted        = r_voted;
  assign ballot_valid = r_valid;

endmodule

// File: tb/tb_ballot_collector.sv
// Scoreboard bench for ballot_collector: a driver plays windows and pushes the
// expected ballot, a negedge monitor pops and compares when ballot_valid rises.
module tb_ballot_collector;
  localparam int unsigned W = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] vote_stb = '0;
  logic [3:0] vote_val = '0;
  logic       busy;
  logic [3:0] ballot;
  logic [3:0] voted;
  logic       ballot_valid;
  logic       ballot_ready = 1'b0;

  ballot_collector #(.NUM_VOTERS(4), .WINDOW_CYCLES(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .vote_stb     (vote_stb),
    .vote_val     (vote_val),
    .busy         (busy),
    .ballot       (ballot),
    .voted        (voted),
    .ballot_valid (ballot_valid),
    .ballot_ready (ballot_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ballot;
    logic [3:0] voted;
    int         open_cycles;
  } exp_t;

  exp_t q_exp[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [3:0] p_stb[W];
  logic [3:0] p_val[W];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic clear_plan();
    for (int i = 0; i < int'(W); i++) begin
      p_stb[i] = '0;
      p_val[i] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a window closes when everyone has voted or after W cycles.
  task automatic run_window(input int hold_cycles, input bit early_ready, input bit force_start);
    logic [3:0] m_ballot = '0;
    logic [3:0] m_voted  = '0;
    int         k = 0;
    bit         closed = 0;
    for (int j = 0; j < 2; j++) begin
      vote_stb = 4'($urandom);
      vote_val = 4'($urandom);
      tick();
      chk("idle_busy", busy, 1'b0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    ballot_ready = early_ready;
    while (!closed) begin
      vote_stb = p_stb[k];
      vote_val = p_val[k];
      for (int n = 0; n < 4; n++) begin
        if (vote_stb[n]) begin
`ifdef BALLOT_LOCK_EN
          if (!m_voted[n]) m_ballot[n] = vote_val[n];
`else
          m_ballot[n] = vote_val[n];
`endif
          m_voted[n] = 1'b1;
        end
      end
      k++;
      closed = (m_voted == 4'hF) || (k == int'(W));
      tick();
    end
    q_exp.push_back('{m_ballot, m_voted, k});
    for (int j = 0; j < hold_cycles; j++) begin
      vote_stb = 4'($urandom);
      vote_val = 4'($urandom);
      start = (force_start && j == 2) | 1'($urandom);
      tick();
      chk("hold_busy", busy, 1'b1);
    end
    start = 1'b0;
    ballot_ready = 1'b1;
    vote_stb = 4'($urandom);
    tick();
    ballot_ready = 1'b0;
    vote_stb = '0;
    chk("post_ack_valid", ballot_valid, 1'b0);
    chk("post_ack_busy", busy, 1'b0);
    tick();
    chk("no_queued_start", busy, 1'b0);
  endtask

  task automatic reset_mid_open();
    start = 1'b1;
    tick();
    start = 1'b0;
    vote_stb = 4'b0011;
    vote_val = 4'b0011;
    tick();
    vote_stb = 4'b0000;
    tick();
    chk("pre_rst_voted", voted, 4'b0011);
    rst = 1'b1;
    start = 1'b1;
    vote_stb = 4'hF;
    vote_val = 4'hF;
    tick();
    chk("rst_ballot", ballot, 4'h0);
    chk("rst_voted", voted, 4'h0);
    chk("rst_valid", ballot_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    start = 1'b0;
    vote_stb = '0;
    vote_val = '0;
    tick();
    chk("rst_idle", busy, 1'b0);
  endtask

  // Monitor: compares on each ballot_valid rise, then checks the hold is frozen.
  initial begin
    int   cnt = 0;
    logic prev_valid = 1'b0;
    exp_t cur = '{4'h0, 4'h0, 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt = 0;
        prev_valid = 1'b0;
      end else begin
        if (ballot_valid && !prev_valid) begin
          if (q_exp.size() == 0) begin
            chk("unexpected_valid", 1'b1, 1'b0);
          end else begin
            cur = q_exp.pop_front();
            chk("ballot", ballot, cur.ballot);
            chk("voted", voted, cur.voted);
            chk("open_cycles", cnt, cur.open_cycles);
          end
        end else if (ballot_valid) begin
          chk("frozen_ballot", ballot, cur.ballot);
          chk("frozen_voted", voted, cur.voted);
        end
        if (busy && !ballot_valid) cnt++;
        else if (!busy) cnt = 0;
        prev_valid = ballot_valid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) tick();
    chk("reset_busy", busy, 1'b0);
    chk("reset_valid", ballot_valid, 1'b0);
    chk("reset_ballot", ballot, 4'h0);
    chk("reset_voted", voted, 4'h0);
    rst = 1'b0;
    tick();

    // All voters in the first cycle: early close.
    clear_plan();
    p_stb[0] = 4'hF; p_val[0] = 4'b1011;
    run_window(0, 1'b0, 1'b0);

    // Voters 0 and 2 say yes, window times out; voter 3 votes on the final cycle.
    clear_plan();
    p_stb[2] = 4'b0101; p_val[2] = 4'b0101;
    run_window(1, 1'b0, 1'b0);
    clear_plan();
    p_stb[1] = 4'b0101; p_val[1] = 4'b0101;
    p_stb[W-1] = 4'b1000; p_val[W-1] = 4'b1000;
    run_window(0, 1'b0, 1'b0);

    // Voter 1 changes its mind within the window.
    clear_plan();
    p_stb[0] = 4'b0010; p_val[0] = 4'b0010;
    p_stb[3] = 4'b0010; p_val[3] = 4'b0000;
    run_window(0, 1'b0, 1'b0);

    // Long hold with ready low and a start pulse; then ready held high beforehand.
    clear_plan();
    p_stb[0] = 4'b1111; p_val[0] = 4'b0110;
    run_window(5, 1'b0, 1'b1);
    clear_plan();
    p_stb[1] = 4'b1111; p_val[1] = 4'b1001;
    run_window(0, 1'b1, 1'b0);

    reset_mid_open();
    clear_plan();
    p_stb[4] = 4'b0100; p_val[4] = 4'b0000;
    run_window(0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      bit er;
      for (int c = 0; c < int'(W); c++) begin
        p_stb[c] = 4'($urandom & $urandom & $urandom);
        p_val[c] = 4'($urandom);
      end
      er = ($urandom_range(0, 3) == 0);
      run_window(er ? 0 : int'($urandom_range(0, 4)), er, 1'b0);
    end

    repeat (2) tick();
    chk("queue_drained", q_exp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
